// File: rtl/bp_pkg.sv
// Shared branch-predictor types: PHT counter, predictor FSM states and
// the saturating counter update.
package bp_pkg;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t PHT_WEAK_NT = 2'b01;

    typedef enum logic {
        INIT,
        READY
    } gshare_state_t;

    // 2-bit saturating counter: TAKEN counts up to 11, NOT TAKEN down to 00.
    function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t res;
        res = ctr;
        if (taken && (ctr != 2'b11)) begin
            res = ctr + 2'b01;
        end else if (!taken && (ctr != 2'b00)) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_idx_fifo.sv
// In-order FIFO of PHT indices awaiting resolution. Occupancy counter decides
// full/empty; clear wins over push, and a pop may coincide with clear.
module gshare_idx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap modulo DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a PHT of 2-bit
// counters; prediction indices are queued so training hits the same entry.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned HISTORY_SIZE = 64,
    parameter int unsigned INDEX_BITS   = 10,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [HISTORY_SIZE-1:0]       history,
    input  logic                          pred_req_valid,
    input  logic [31:0]                   pred_req_pc,
    output logic                          pred_ready,
    output logic                          pred_valid,
    output logic                          pred_taken,
    input  logic                          upd_valid,
    input  logic                          upd_outcome,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   outstanding,
    output logic                          upd_underflow
);

    localparam int unsigned PHT_ENTRIES = 1 << INDEX_BITS;

    gshare_state_t         state;
    gshare_state_t         state_next;
    logic [INDEX_BITS-1:0] init_idx;
    logic [INDEX_BITS-1:0] init_idx_next;

    pht_ctr_t              pht [PHT_ENTRIES];
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    pht_ctr_t              wr_data;

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  upd;
    logic                  pop;
    logic                  unused_bits;

    assign idx         = pred_req_pc[INDEX_BITS+1:2] ^ history[INDEX_BITS-1:0];
    assign unused_bits = ^{pred_req_pc[31:INDEX_BITS+2], pred_req_pc[1:0], history};

    // pred_ready sees the registered occupancy, so a same-cycle pop cannot relieve a full FIFO.
    assign pred_ready = (state == READY) && !flush && !fifo_full;
    assign accept     = pred_req_valid && pred_ready;
    assign upd        = upd_valid && (state == READY);
    assign pop        = upd && !fifo_empty;

    gshare_idx_fifo #(
        .WIDTH (INDEX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_idx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .data  (idx),
        .pop   (pop),
        .clear (flush),
        .head  (head),
        .count (outstanding),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
        end
    end

    // INIT sweeps every PHT entry to weak-NT; READY owns the single training write port.
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        wr_en         = 1'b0;
        wr_idx        = init_idx;
        wr_data       = PHT_WEAK_NT;
        case (state)
            INIT: begin
                wr_en         = 1'b1;
                init_idx_next = init_idx + INDEX_BITS'(1);
                if (&init_idx) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (pop) begin
                    wr_en   = 1'b1;
                    wr_idx  = head;
                    wr_data = sat_update(pht[head], upd_outcome);
                end
            end
            default: begin
                state_next    = INIT;
                init_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht[wr_idx] <= wr_data;
        end
    end

    // Lookup reads the pre-write counter, giving read-before-write on index collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid    <= 1'b0;
            pred_taken    <= 1'b0;
            upd_underflow <= 1'b0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_taken <= pht[idx][1];
            end
            if (upd && fifo_empty) begin
                upd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus random
// traffic against a table-and-queue reference model.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] history = '0;
    logic        pred_req_valid = 1'b0;
    logic [31:0] pred_req_pc = '0;
    logic        pred_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic        upd_outcome = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  outstanding;
    logic        upd_underflow;

    int checks = 0;
    int errors = 0;

    int model [1024];
    int q [$];
    bit m_uf;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .history        (history),
        .pred_req_valid (pred_req_valid),
        .pred_req_pc    (pred_req_pc),
        .pred_ready     (pred_ready),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_outcome    (upd_outcome),
        .flush          (flush),
        .outstanding    (outstanding),
        .upd_underflow  (upd_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int hash(input logic [31:0] pc, input logic [63:0] h);
        return int'(((pc >> 2) ^ h[31:0]) & 32'h3FF);
    endfunction

    task automatic model_reset();
        foreach (model[i]) model[i] = 1;
        q.delete();
        m_uf = 1'b0;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit req, input logic [31:0] pc, input logic [63:0] hist,
                        input bit upd, input bit outc, input bit fl);
        bit exp_ready;
        bit acc;
        bit exp_pt;
        int ix;
        pred_req_valid = req;
        pred_req_pc    = pc;
        history        = hist;
        upd_valid      = upd;
        upd_outcome    = outc;
        flush          = fl;
        #1;
        exp_ready = !fl && (q.size() < 8);
        check("pred_ready", 32'(pred_ready), 32'(exp_ready));
        acc    = req && exp_ready;
        ix     = hash(pc, hist);
        exp_pt = (model[ix] >= 2);
        if (upd) begin
            if (q.size() > 0) begin
                int h;
                h = q.pop_front();
                model[h] = outc ? ((model[h] < 3) ? model[h] + 1 : 3)
                                : ((model[h] > 0) ? model[h] - 1 : 0);
            end else begin
                m_uf = 1'b1;
            end
        end
        if (fl) q.delete();
        else if (acc) q.push_back(ix);
        @(posedge clk);
        #1;
        pred_req_valid = 1'b0;
        upd_valid      = 1'b0;
        flush          = 1'b0;
        check("pred_valid", 32'(pred_valid), 32'(acc));
        if (acc) check("pred_taken", 32'(pred_taken), 32'(exp_pt));
        check("outstanding", 32'(outstanding), 32'(q.size()));
        check("upd_underflow", 32'(upd_underflow), 32'(m_uf));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 16) begin
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
    endtask

    // Counts cycles until pred_ready rises, holding upd_valid high to prove it is ignored.
    task automatic wait_ready(output int n);
        n = 0;
        upd_valid = 1'b1;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (pred_ready) break;
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] pc;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pred_ready", 32'(pred_ready), 32'h0);
        check("rst_pred_valid", 32'(pred_valid), 32'h0);
        check("rst_pred_taken", 32'(pred_taken), 32'h0);
        check("rst_outstanding", 32'(outstanding), 32'h0);
        check("rst_underflow", 32'(upd_underflow), 32'h0);

        rst_n = 1'b1;
        wait_ready(n);
        check("init_cycles", 32'(n), 32'd1024);
        check("init_no_underflow", 32'(upd_underflow), 32'h0);

        // Training on pc 0x0040_0010, history 0 (idx 4).
        step(1, 32'h0040_0010, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h0040_0010, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h0040_0010, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0040_0010, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0040_0010, 0, 0, 0, 0);
        check("train_final_nt", 32'(pred_taken), 32'h0);
        drain();

        // Hash aliasing onto idx 0.
        step(1, 32'h10, 64'h4, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h0, 64'h0, 0, 0, 0);
        check("alias_taken", 32'(pred_taken), 32'h1);
        drain();

        // FIFO full and relief one cycle after a pop.
        for (int i = 0; i < 8; i++) step(1, $urandom, 64'($urandom), 0, 0, 0);
        step(1, 32'h40, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h44, 0, 0, 0, 0);
        drain();

        // Flush with a same-cycle update, then underflow.
        for (int i = 0; i < 3; i++) step(1, 32'h80 + 32'(i * 4), 0, 0, 0, 0);
        step(1, 32'h80, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h84, 0, 0, 0, 0);
        drain();

        // Same-cycle accept + update on idx 64: read-before-write.
        step(1, 32'h100, 0, 0, 0, 0);
        step(1, 32'h100, 0, 1, 1, 0);
        check("rbw_old_value", 32'(pred_taken), 32'h0);
        step(1, 32'h100, 0, 0, 0, 0);
        check("rbw_new_value", 32'(pred_taken), 32'h1);
        drain();

        // Random traffic over a small index set to force collisions.
        for (int i = 0; i < 2000; i++) begin
            pc = $urandom & 32'h3C;
            step(1'($urandom_range(0, 2) != 0), pc, 64'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0));
        end
        drain();

        // Reset mid-operation with entries outstanding.
        for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i * 4), 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midop_outstanding", 32'(outstanding), 32'h0);
        check("midop_ready", 32'(pred_ready), 32'h0);
        check("midop_underflow", 32'(upd_underflow), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Reset again at init cycle 500: the full sweep restarts.
        repeat (500) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midinit_ready", 32'(pred_ready), 32'h0);
        rst_n = 1'b1;
        wait_ready(n);
        check("reinit_cycles", 32'(n), 32'd1024);
        step(1, 32'h10, 64'h4, 0, 0, 0);
        step(1, 32'h100, 0, 0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
